processing_unit_multi_context: RTL and testbench

//  Next-generation union-find decoder PE for Z ancillas. Fully parametrised in neighbour count and

---
 rtl/processing_unit_multi_context.sv | 244 ++++++++++++++++++++++++
 tb/tb_processing_unit_multi_context.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/processing_unit_multi_context.sv
// Union-find decoder processing element for one Z-ancilla vertex, with a
// NUM_CONTEXTS-deep context store and a save/restore handshake.
module processing_unit_multi_context #(
  parameter int unsigned ADDRESS_WIDTH  = 6,
  parameter int unsigned NEIGHBOR_COUNT = 6,
  parameter int unsigned NUM_CONTEXTS   = 4,
  parameter int unsigned STAGE_WIDTH    = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0,
  parameter logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1,
  parameter logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2,
  parameter logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4,
  parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = 3'd5,
  localparam int unsigned CTX_W             = $clog2(NUM_CONTEXTS),
  localparam int unsigned EXPOSED_DATA_SIZE = ADDRESS_WIDTH + 3
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        measurement,
  output logic                                        measurement_out,
  input  logic [STAGE_WIDTH-1:0]                      global_stage,
  input  logic [ADDRESS_WIDTH-1:0]                    input_address,
  input  logic [NEIGHBOR_COUNT-1:0]                   neighbor_fully_grown,
  input  logic [NEIGHBOR_COUNT-1:0]                   neighbor_is_boundary,
  output logic                                        neighbor_increase,
  output logic [NEIGHBOR_COUNT-1:0]                   neighbor_is_error,
  input  logic [NEIGHBOR_COUNT*EXPOSED_DATA_SIZE-1:0] input_data,
  output logic [NEIGHBOR_COUNT*EXPOSED_DATA_SIZE-1:0] output_data,
  input  logic                                        ctx_req,
  input  logic [CTX_W-1:0]                            ctx_next,
  output logic                                        ctx_done,
  output logic                                        ctx_err,
  output logic [CTX_W-1:0]                            current_ctx,
  output logic [ADDRESS_WIDTH-1:0]                    root,
  output logic                                        odd,
  output logic                                        busy
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned NB = NEIGHBOR_COUNT;
  localparam int unsigned E  = EXPOSED_DATA_SIZE;
  localparam int unsigned MW = NB + AW + 3;
  localparam logic [CTX_W:0]   NC_L     = (CTX_W + 1)'(NUM_CONTEXTS);
  localparam logic [CTX_W-1:0] LAST_CTX = CTX_W'(NUM_CONTEXTS - 1);

  typedef enum logic [1:0] {CTX_IDLE, CTX_SAVE, CTX_LOAD} ctx_state_e;

  ctx_state_e state_q, state_d;
  logic [STAGE_WIDTH-1:0] stage_q, last_stage_q;
  logic [AW-1:0] root_q, root_d;
  logic [NB-1:0] parent_q, parent_d;
  logic odd_q, odd_d, cp_q, cp_d, m_q, m_d, busy_q, busy_d;
  logic [CTX_W-1:0] cur_ctx_q, cur_ctx_d, tgt_q, tgt_d;
  logic done_q, done_d, err_q, err_d;
  logic [NUM_CONTEXTS-1:0] valid_q, valid_d;
  logic [MW-1:0] mem_q [NUM_CONTEXTS];
  logic [MW-1:0] rd_word_q;
  logic          rd_valid_q;

  logic [AW-1:0] in_root [NB];
  logic [NB-1:0] in_pbit, in_odd, in_par;
  logic [NB-1:0] cand, min_oh, border;
  logic [AW-1:0] min_root, root_mod;
  logic          has_cand, any_bnd, np, idle, wtm_trig;
  logic [CTX_W:0]   ctx_next_ext;
  logic [CTX_W-1:0] next_wrap;

  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      in_root[i] = input_data[i*E +: AW];
      in_pbit[i] = input_data[i*E + AW];
      in_odd[i]  = input_data[i*E + AW + 1];
      in_par[i]  = input_data[i*E + AW + 2];
    end
  end

  // Minimum root over grown non-boundary links; strict < keeps the lowest index on ties.
  always_comb begin
    cand     = neighbor_fully_grown & ~neighbor_is_boundary;
    has_cand = 1'b0;
    min_root = '1;
    min_oh   = '0;
    border   = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (cand[i] && (!has_cand || in_root[i] < min_root)) begin
        has_cand  = 1'b1;
        min_root  = in_root[i];
        min_oh    = '0;
        min_oh[i] = 1'b1;
      end
    end
    any_bnd  = |neighbor_is_boundary;
    root_mod = any_bnd ? {1'b0, input_address[AW-2:0]} : root_q;
    np       = (^(in_pbit & in_par)) ^ m_q;
    if (parent_q == '0 && np) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (neighbor_is_boundary[i]) begin
          border    = '0;
          border[i] = 1'b1;
        end
      end
    end
  end

  assign idle         = (state_q == CTX_IDLE);
  // Stage-triggered switch fires on entry only, so a held WRITE_TO_MEM stage does not re-switch.
  assign wtm_trig     = (stage_q == STAGE_WRITE_TO_MEM) && (last_stage_q != STAGE_WRITE_TO_MEM);
  assign ctx_next_ext = {1'b0, ctx_next};
  assign next_wrap    = (cur_ctx_q == LAST_CTX) ? '0 : cur_ctx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    root_d    = root_q;
    parent_d  = parent_q;
    odd_d     = odd_q;
    cp_d      = cp_q;
    m_d       = m_q;
    busy_d    = busy_q;
    cur_ctx_d = cur_ctx_q;
    tgt_d     = tgt_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      CTX_IDLE: begin
        if (ctx_req) begin
          if (ctx_next_ext >= NC_L) begin
            err_d = 1'b1;
          end else if (ctx_next == cur_ctx_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = ctx_next;
            state_d = CTX_SAVE;
          end
        end else if (wtm_trig) begin
          tgt_d   = next_wrap;
          state_d = CTX_SAVE;
        end
        if (stage_q == STAGE_MEASUREMENT_LOADING) begin
          m_d      = measurement;
          odd_d    = measurement;
          cp_d     = measurement;
          root_d   = input_address;
          parent_d = '0;
        end else if (stage_q == STAGE_MERGE) begin
          if (has_cand && min_root < root_mod && min_root < root_q) begin
            root_d   = min_root;
            parent_d = min_oh;
          end else if (root_mod < root_q) begin
            root_d   = root_mod;
            parent_d = '0;
          end
          cp_d   = np;
          odd_d  = (|parent_q) ? |(parent_q & in_odd) : (np & ~any_bnd);
          busy_d = (root_d != root_q) || (cp_d != cp_q) || (odd_d != odd_q);
        end
      end
      CTX_SAVE: begin
        valid_d[cur_ctx_q] = 1'b1;
        state_d            = CTX_LOAD;
      end
      CTX_LOAD: begin
        if (rd_valid_q) begin
          cp_d     = rd_word_q[MW-1];
          parent_d = rd_word_q[AW+2 +: NB];
          root_d   = rd_word_q[2 +: AW];
          odd_d    = rd_word_q[1];
          m_d      = rd_word_q[0];
        end else begin
          cp_d     = 1'b0;
          parent_d = '0;
          root_d   = input_address;
          odd_d    = 1'b0;
          m_d      = 1'b0;
        end
        cur_ctx_d = tgt_q;
        done_d    = 1'b1;
        state_d   = CTX_IDLE;
      end
      default: state_d = CTX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    stage_q      <= global_stage;
    last_stage_q <= stage_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CTX_IDLE;
      root_q    <= '0;
      parent_q  <= '0;
      odd_q     <= 1'b0;
      cp_q      <= 1'b0;
      m_q       <= 1'b0;
      busy_q    <= 1'b0;
      cur_ctx_q <= '0;
      tgt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      root_q    <= root_d;
      parent_q  <= parent_d;
      odd_q     <= odd_d;
      cp_q      <= cp_d;
      m_q       <= m_d;
      busy_q    <= busy_d;
      cur_ctx_q <= cur_ctx_d;
      tgt_q     <= tgt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CTX_SAVE) begin
      mem_q[cur_ctx_q] <= {cp_q, parent_q, root_q, odd_q, m_q};
      rd_word_q        <= mem_q[tgt_q];
      rd_valid_q       <= valid_q[tgt_q];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      output_data[i*E +: E] = {cp_q, odd_q, parent_q[i], root_q};
    end
  end

  assign neighbor_increase = idle && (stage_q == STAGE_GROW) && (last_stage_q != STAGE_GROW) && odd_q;
  assign neighbor_is_error = (idle && stage_q == STAGE_PEELING) ?
                             ((cp_q ? parent_q : '0) | border) : '0;
  assign measurement_out   = m_q;
  assign ctx_done          = done_q;
  assign ctx_err           = err_q;
  assign current_ctx       = cur_ctx_q;
  assign root              = root_q;
  assign odd               = odd_q;
  assign busy              = busy_q | ~idle;

endmodule

// File: tb/tb_processing_unit_multi_context.sv
// Directed bench for processing_unit_multi_context with three contexts so the
// out-of-range context request is reachable on a 2-bit ctx_next.
module tb_processing_unit_multi_context;

  localparam int unsigned AW = 6;
  localparam int unsigned NB = 6;
  localparam int unsigned NC = 3;
  localparam int unsigned CW = 2;
  localparam int unsigned E  = AW + 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_GROW = 3'd2,
                         S_MERGE = 3'd3, S_PEEL = 3'd4, S_WTM = 3'd5;

  logic clk = 1'b0;
  logic reset;
  logic measurement;
  logic measurement_out;
  logic [2:0] global_stage;
  logic [AW-1:0] input_address;
  logic [NB-1:0] neighbor_fully_grown, neighbor_is_boundary;
  logic neighbor_increase;
  logic [NB-1:0] neighbor_is_error;
  logic [NB*E-1:0] input_data, output_data;
  logic ctx_req;
  logic [CW-1:0] ctx_next;
  logic ctx_done, ctx_err;
  logic [CW-1:0] current_ctx;
  logic [AW-1:0] root;
  logic odd, busy;

  int total = 0;
  int bad   = 0;

  processing_unit_multi_context #(
    .ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(NB), .NUM_CONTEXTS(NC), .STAGE_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .measurement(measurement), .measurement_out(measurement_out),
    .global_stage(global_stage), .input_address(input_address),
    .neighbor_fully_grown(neighbor_fully_grown), .neighbor_is_boundary(neighbor_is_boundary),
    .neighbor_increase(neighbor_increase), .neighbor_is_error(neighbor_is_error),
    .input_data(input_data), .output_data(output_data),
    .ctx_req(ctx_req), .ctx_next(ctx_next), .ctx_done(ctx_done), .ctx_err(ctx_err),
    .current_ctx(current_ctx), .root(root), .odd(odd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_link(input int i, input logic par, input logic od, input logic pb,
                          input logic [AW-1:0] r);
    input_data[i*E +: E] = {par, od, pb, r};
  endtask

  // Output field of link i: {cluster_parity, odd, parent_bit, root}
  function automatic logic [E-1:0] fld(input int i);
    return output_data[i*E +: E];
  endfunction

  task automatic req(input logic [CW-1:0] c);
    ctx_req  = 1'b1;
    ctx_next = c;
    tick(1);
    ctx_req  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; measurement = 1'b0; global_stage = S_IDLE; input_address = '0;
    neighbor_fully_grown = '0; neighbor_is_boundary = '0; input_data = '0;
    ctx_req = 1'b0; ctx_next = '0;
    tick(2);
    check("rst_root", 32'(root), 32'h0);
    check("rst_odd", 32'(odd), 32'h0);
    check("rst_m", 32'(measurement_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ctx", 32'(current_ctx), 32'h0);
    check("rst_done", 32'(ctx_done), 32'h0);

    // T1 loading
    reset = 1'b1; measurement = 1'b1; input_address = 6'h05; global_stage = S_LOAD;
    tick(2);
    check("t1_root", 32'(root), 32'h05);
    check("t1_odd", 32'(odd), 32'h1);
    check("t1_cp", 32'(fld(0)), 32'h185);
    check("t1_m", 32'(measurement_out), 32'h1);

    // GROW request only on the first GROW cycle
    global_stage = S_GROW;
    tick(1);
    check("grow_first", 32'(neighbor_increase), 32'h1);
    tick(1);
    check("grow_second", 32'(neighbor_increase), 32'h0);

    // T2 merge: links 2 and 4 grown with root 03, tie to link 2
    for (int i = 0; i < 6; i++)
      set_link(i, 1'b0, (i == 2), 1'b0, (i == 2 || i == 4) ? 6'h03 : 6'h3F);
    neighbor_fully_grown = 6'b010100;
    global_stage = S_MERGE;
    tick(2);
    check("t2_root", 32'(root), 32'h03);
    check("t2_link2", 32'(fld(2)), 32'h1C3);
    check("t2_link4", 32'(fld(4)), 32'h183);
    check("t2_busy1", 32'(busy), 32'h1);
    check("t2_noerr", 32'(neighbor_is_error), 32'h0);
    tick(1);
    check("t2_busy0", 32'(busy), 32'h0);
    check("t2_odd", 32'(odd), 32'h1);

    // T4 save state A in ctx0, switch to unwritten ctx1, then back
    global_stage = S_IDLE;
    tick(1);
    req(2'd1);
    check("t4_busy_save", 32'(busy), 32'h1);
    check("t4_nodone1", 32'(ctx_done), 32'h0);
    tick(1);
    check("t4_nodone2", 32'(ctx_done), 32'h0);
    tick(1);
    check("t4_done", 32'(ctx_done), 32'h1);
    check("t4_ctx1", 32'(current_ctx), 32'h1);
    check("t4_fresh", 32'(fld(2)), 32'h005);
    check("t4_fresh_m", 32'(measurement_out), 32'h0);
    tick(1);
    check("t4_done_pulse", 32'(ctx_done), 32'h0);
    req(2'd0);
    tick(2);
    check("t4_back_done", 32'(ctx_done), 32'h1);
    check("t4_back_ctx", 32'(current_ctx), 32'h0);
    check("t4_restore2", 32'(fld(2)), 32'h1C3);
    check("t4_restore4", 32'(fld(4)), 32'h183);
    check("t4_restore_m", 32'(measurement_out), 32'h1);

    // T5 out-of-range, same-context, request during SAVE
    tick(1);
    req(2'd3);
    check("t5_err", 32'(ctx_err), 32'h1);
    check("t5_err_nodone", 32'(ctx_done), 32'h0);
    check("t5_err_ctx", 32'(current_ctx), 32'h0);
    check("t5_err_root", 32'(root), 32'h03);
    tick(1);
    check("t5_err_pulse", 32'(ctx_err), 32'h0);
    req(2'd0);
    check("t5_same_done", 32'(ctx_done), 32'h1);
    check("t5_same_busy", 32'(busy), 32'h0);
    req(2'd2);
    req(2'd1);
    tick(1);
    check("t5_ign_done", 32'(ctx_done), 32'h1);
    check("t5_ign_ctx", 32'(current_ctx), 32'h2);
    check("t5_ign_root", 32'(root), 32'h05);
    tick(1);
    check("t5_idle_busy", 32'(busy), 32'h0);

    // WRITE_TO_MEM stage: ctx2 -> ctx0 wrap
    global_stage = S_WTM;
    tick(4);
    check("wtm_done", 32'(ctx_done), 32'h1);
    check("wtm_ctx", 32'(current_ctx), 32'h0);
    check("wtm_root", 32'(root), 32'h03);
    global_stage = S_IDLE;
    tick(2);
    check("wtm_once", 32'(current_ctx), 32'h0);

    // T6 reset during SAVE
    req(2'd1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("t6_ctx", 32'(current_ctx), 32'h0);
    check("t6_root", 32'(root), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    input_address = 6'h0A;
    req(2'd2);
    tick(2);
    check("t6_done", 32'(ctx_done), 32'h1);
    check("t6_fresh_root", 32'(root), 32'h0A);
    check("t6_fresh_ctx", 32'(current_ctx), 32'h2);

    // T3 boundary merge and peeling
    input_address = 6'h25; measurement = 1'b1; global_stage = S_LOAD;
    tick(2);
    check("t3_load_root", 32'(root), 32'h25);
    for (int i = 0; i < 6; i++) set_link(i, 1'b0, 1'b0, 1'b0, 6'h3F);
    neighbor_fully_grown = 6'b100100;
    neighbor_is_boundary = 6'b100100;
    global_stage = S_MERGE;
    tick(2);
    check("t3_root", 32'(root), 32'h05);
    check("t3_odd", 32'(odd), 32'h0);
    check("t3_busy", 32'(busy), 32'h1);
    global_stage = S_PEEL;
    tick(1);
    check("t3_err", 32'(neighbor_is_error), 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
